mmio_memory: RTL and testbench



---
 rtl/mmio_pkg.sv | 10 +
 rtl/mmio_input_sync.sv | 32 +++
 rtl/mmio_memory.sv | 179 +++++++++++++++++
 tb/tb_mmio_memory.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// Shared constants for the memory-mapped I/O page.
// Offsets within the page and TIMER_CTRL bit positions.
package mmio_pkg;
    localparam logic [3:0] OFF_IN_STATUS   = 4'd8;
    localparam logic [3:0] OFF_IN_FLAGS    = 4'd9;
    localparam logic [3:0] OFF_TIMER_COUNT = 4'd10;
    localparam logic [3:0] OFF_TIMER_CTRL  = 4'd11;
    localparam int EN_BIT  = 0;
    localparam int OVF_BIT = 15;
endpackage

// File: rtl/mmio_input_sync.sv
// Two-flop input synchroniser with a prev stage and sticky
// change flags; set wins over a same-cycle clear.
module mmio_input_sync #(
    parameter int IN_WIDTH = 4
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [IN_WIDTH-1:0] pins,
    input  logic [IN_WIDTH-1:0] clear,
    output logic [IN_WIDTH-1:0] status,
    output logic [IN_WIDTH-1:0] flags
);
    logic [IN_WIDTH-1:0] sync1;
    logic [IN_WIDTH-1:0] sync2;
    logic [IN_WIDTH-1:0] prev;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
            flags <= '0;
        end else begin
            sync1 <= pins;
            sync2 <= sync1;
            prev  <= sync2;
            flags <= (flags & ~clear) | (sync2 ^ prev);
        end
    end

    assign status = sync2;
endmodule

// File: rtl/mmio_memory.sv
// Data RAM plus I/O page (output regs, input port, optional timer).
// Timer present only when MMIO_MEMORY_TIMER_EN is defined.
module mmio_memory
    import mmio_pkg::*;
#(
    parameter int DATA_WIDTH     = 16,
    parameter int ADDR_WIDTH     = 15,
    parameter int RAM_ADDR_WIDTH = 14,
    parameter int NUM_OUT        = 4,
    parameter int IN_WIDTH       = 4,
    parameter int PRESCALE       = 1000
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic [DATA_WIDTH-1:0]         in,
    input  logic [ADDR_WIDTH-1:0]         address,
    input  logic                          load,
    output logic [DATA_WIDTH-1:0]         out,
    output logic [NUM_OUT*DATA_WIDTH-1:0] out_regs,
    input  logic [IN_WIDTH-1:0]           pins_in
);
    localparam int RAM_DEPTH = 1 << RAM_ADDR_WIDTH;

    if (NUM_OUT < 1 || NUM_OUT > 8 || PRESCALE < 1 ||
        IN_WIDTH > DATA_WIDTH ||
        RAM_ADDR_WIDTH > ADDR_WIDTH - 1) begin : g_bad_params
        $error("mmio_memory: illegal parameter set");
    end

    logic                      io_sel;
    logic [3:0]                off;
    logic [RAM_ADDR_WIDTH-1:0] ram_idx;
    logic                      wr;
    logic                      io_wr;

    assign io_sel  = address[ADDR_WIDTH-1];
    assign off     = address[3:0];
    assign ram_idx = address[RAM_ADDR_WIDTH-1:0];
    // Writes are dropped at any edge seen while reset is held.
    assign wr      = load & reset_n;
    assign io_wr   = wr & io_sel;

    logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];
    logic [DATA_WIDTH-1:0] ram_q;

    always_ff @(posedge clock) begin
        if (wr && !io_sel) begin
            mem[ram_idx] <= in;
        end
        ram_q <= mem[ram_idx];
    end

    logic [DATA_WIDTH-1:0] oreg [NUM_OUT];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < NUM_OUT; k++) begin
                oreg[k] <= '0;
            end
        end else if (io_wr) begin
            for (int k = 0; k < NUM_OUT; k++) begin
                if (off == 4'(k)) begin
                    oreg[k] <= in;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_OUT; g++) begin : g_out
        assign out_regs[g*DATA_WIDTH +: DATA_WIDTH] = oreg[g];
    end

    logic [IN_WIDTH-1:0] clear;
    logic [IN_WIDTH-1:0] status;
    logic [IN_WIDTH-1:0] flags;

    assign clear = (io_wr && off == OFF_IN_FLAGS)
                 ? in[IN_WIDTH-1:0] : '0;

    mmio_input_sync #(
        .IN_WIDTH (IN_WIDTH)
    ) u_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .pins    (pins_in),
        .clear   (clear),
        .status  (status),
        .flags   (flags)
    );

`ifdef MMIO_MEMORY_TIMER_EN
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PW-1:0]         presc;
    logic [DATA_WIDTH-1:0] tcount;
    logic                  t_en;
    logic                  t_ovf;
    logic                  tick;
    logic                  wrap;
    logic                  cnt_wr;
    logic                  ctl_wr;
    logic [DATA_WIDTH-1:0] tctrl;

    assign cnt_wr = io_wr && off == OFF_TIMER_COUNT;
    assign ctl_wr = io_wr && off == OFF_TIMER_CTRL;
    assign tick   = t_en && presc == PW'(PRESCALE - 1);
    // A count write overrides the tick, so it cannot overflow.
    assign wrap   = tick && !cnt_wr && (&tcount);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            presc  <= '0;
            tcount <= '0;
            t_en   <= 1'b0;
            t_ovf  <= 1'b0;
        end else begin
            if (cnt_wr) begin
                tcount <= in;
                presc  <= '0;
            end else if (t_en) begin
                presc <= tick ? '0 : presc + 1'b1;
                if (tick) begin
                    tcount <= tcount + 1'b1;
                end
            end
            if (ctl_wr) begin
                t_en <= in[EN_BIT];
            end
            if (wrap) begin
                t_ovf <= 1'b1;
            end else if (ctl_wr && in[OVF_BIT]) begin
                t_ovf <= 1'b0;
            end
        end
    end

    always_comb begin
        tctrl          = '0;
        tctrl[EN_BIT]  = t_en;
        tctrl[OVF_BIT] = t_ovf;
    end
`endif

    logic [DATA_WIDTH-1:0] io_rd;

    always_comb begin
        io_rd = '0;
        for (int k = 0; k < NUM_OUT; k++) begin
            if (off == 4'(k)) begin
                io_rd = oreg[k];
            end
        end
        case (off)
            OFF_IN_STATUS:   io_rd = DATA_WIDTH'(status);
            OFF_IN_FLAGS:    io_rd = DATA_WIDTH'(flags);
`ifdef MMIO_MEMORY_TIMER_EN
            OFF_TIMER_COUNT: io_rd = tcount;
            OFF_TIMER_CTRL:  io_rd = tctrl;
`endif
            default: ;
        endcase
    end

    logic                  sel_q;
    logic [DATA_WIDTH-1:0] io_q;

    // Reset selects the I/O side so out reads 0 without resetting RAM.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sel_q <= 1'b1;
            io_q  <= '0;
        end else begin
            sel_q <= io_sel;
            io_q  <= io_rd;
        end
    end

    assign out = sel_q ? io_q : ram_q;
endmodule

// File: tb/tb_mmio_memory.sv
// Directed bench for mmio_memory; define MMIO_MEMORY_TIMER_EN
// to exercise the timer instead of the disabled-offset checks.
module tb_mmio_memory;
    logic        clock;
    logic        reset_n;
    logic [15:0] in;
    logic [14:0] address;
    logic        load;
    logic [15:0] out;
    logic [63:0] out_regs;
    logic [3:0]  pins_in;

    int total = 0;
    int bad   = 0;
    logic [15:0] rv;

    mmio_memory #(
        .PRESCALE (4)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .in       (in),
        .address  (address),
        .load     (load),
        .out      (out),
        .out_regs (out_regs),
        .pins_in  (pins_in)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // All tasks start and end on a falling edge.
    task automatic wr(input logic [14:0] a, input logic [15:0] d);
        address = a;
        in      = d;
        load    = 1'b1;
        @(negedge clock);
        load    = 1'b0;
    endtask

    task automatic rd(input logic [14:0] a, output logic [15:0] d);
        address = a;
        load    = 1'b0;
        @(negedge clock);
        d = out;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout got=%0d exp=%0d", 1, 0);
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0;
        load    = 1'b0;
        in      = '0;
        address = '0;
        pins_in = '0;
        @(negedge clock);
        @(negedge clock);
        chk("rst_out", out, 0);
        chk("rst_regs", out_regs, 0);
        reset_n = 1'b1;

        wr(15'h0005, 16'h1234);
        rd(15'h0005, rv);
        chk("ram_rd", rv, 16'h1234);

        address = 15'h0005;
        in      = 16'hBEEF;
        load    = 1'b1;
        @(negedge clock);
        chk("ram_rdfirst", out, 16'h1234);
        load = 1'b0;
        @(negedge clock);
        chk("ram_new", out, 16'hBEEF);

        wr(15'h3FFF, 16'hA5A5);
        rd(15'h3FFF, rv);
        chk("ram_top", rv, 16'hA5A5);

        wr(15'h4001, 16'h00AA);
        chk("oreg1", out_regs, 64'h0000_0000_00AA_0000);
        rd(15'h4001, rv);
        chk("oreg1_rd", rv, 16'h00AA);
        wr(15'h400F, 16'hFFFF);
        chk("off15_wr", out_regs, 64'h0000_0000_00AA_0000);
        rd(15'h400F, rv);
        chk("off15_rd", rv, 0);
        wr(15'h4010, 16'h0011);
        chk("io_alias", out_regs, 64'h0000_0000_00AA_0011);

        address = 15'h4008;
        pins_in = 4'b0101;
        @(negedge clock);
        @(negedge clock);
        chk("status_e2", out, 0);
        @(negedge clock);
        chk("status_e3", out, 16'h0005);
        address = 15'h4009;
        @(negedge clock);
        chk("flags_set", out, 16'h0005);
        wr(15'h4009, 16'h0001);
        rd(15'h4009, rv);
        chk("flags_w1c", rv, 16'h0004);

        pins_in = 4'b0001;
        @(negedge clock);
        @(negedge clock);
        address = 15'h4009;
        in      = 16'h0004;
        load    = 1'b1;
        @(negedge clock);
        load = 1'b0;
        @(negedge clock);
        chk("set_wins", out, 16'h0004);
        wr(15'h4009, 16'h0004);
        rd(15'h4009, rv);
        chk("flags_clr", rv, 0);
        rd(15'h4008, rv);
        chk("status_new", rv, 16'h0001);

`ifdef MMIO_MEMORY_TIMER_EN
        wr(15'h400A, 16'hFFFE);
        wr(15'h400B, 16'h0001);
        address = 15'h400A;
        repeat (4) @(negedge clock);
        chk("tmr_e4", out, 16'hFFFE);
        @(negedge clock);
        chk("tmr_e5", out, 16'hFFFF);
        repeat (3) @(negedge clock);
        chk("tmr_e8", out, 16'hFFFF);
        @(negedge clock);
        chk("tmr_wrap", out, 16'h0000);
        address = 15'h400B;
        @(negedge clock);
        chk("tmr_ovf", out, 16'h8001);
        wr(15'h400B, 16'h8001);
        rd(15'h400B, rv);
        chk("tmr_ovf_clr", rv, 16'h0001);
        wr(15'h400A, 16'h0010);
        rd(15'h400A, rv);
        chk("tmr_load", rv, 16'h0010);
        wr(15'h400B, 16'h0000);
`else
        wr(15'h400A, 16'h1234);
        wr(15'h400B, 16'h8001);
        rd(15'h400A, rv);
        chk("no_tmr_cnt", rv, 0);
        rd(15'h400B, rv);
        chk("no_tmr_ctl", rv, 0);
`endif

        wr(15'h4000, 16'h7777);
        rd(15'h4000, rv);
        chk("oreg0_rd", rv, 16'h7777);
        address = 15'h4000;
        in      = 16'h5555;
        load    = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        chk("rst_mid_regs", out_regs, 0);
        chk("rst_mid_out", out, 0);
        @(negedge clock);
        load    = 1'b0;
        reset_n = 1'b1;
        chk("rst_lost", out_regs, 0);
        rd(15'h4001, rv);
        chk("rst_oreg1", rv, 0);
        rd(15'h0005, rv);
        chk("ram_kept", rv, 16'hBEEF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
